// File: rtl/game_host_if.sv
// Host-to-GAME bundle: round stimulus out, game status back.
// master = game_host, slave = GAME instance.
interface game_host_if #(
  parameter int INPUT = 4
);
  logic [1:0]       controlValue;
  logic [INPUT-1:0] initialValue;
  logic             INIT;
  logic             WINNER;
  logic             LOSER;
  logic             GAMEOVER;
  logic [1:0]       WHO;

  modport master (
    output controlValue,
    output initialValue,
    output INIT,
    input  WINNER,
    input  LOSER,
    input  GAMEOVER,
    input  WHO
  );

  modport slave (
    input  controlValue,
    input  initialValue,
    input  INIT,
    output WINNER,
    output LOSER,
    output GAMEOVER,
    output WHO
  );
endinterface

// File: rtl/game_host.sv
// game_host: runs a session of ROUNDS games against one GAME block
// and keeps saturating win/loss/timeout scores.
module game_host #(
  parameter int INPUT       = 4,
  parameter int ROUNDS      = 4,
  parameter int INIT_CYCLES = 2,
  parameter int TIMEOUT     = 255,
  parameter int SCORE_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         mode_base,
  input  logic [INPUT-1:0]   seed,
  game_host_if.master        gif,
  output logic               busy,
  output logic               done,
  output logic [SCORE_W-1:0] win_count,
  output logic [SCORE_W-1:0] lose_count,
  output logic [SCORE_W-1:0] timeout_count,
  output logic [1:0]         last_who
);

  localparam int TMAX = (TIMEOUT > INIT_CYCLES) ? TIMEOUT : INIT_CYCLES;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam logic [SCORE_W-1:0] SMAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    NEXT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [TW-1:0]    tmr;
  logic [TW-1:0]    tmr_nx;
  logic [3:0]       rnd;
  logic [3:0]       rnd_nx;
  logic [1:0]       mb_q;
  logic [INPUT-1:0] sd_q;
  logic [1:0]       mb_src;
  logic [INPUT-1:0] sd_src;
  logic             win_q;
  logic             lose_q;
  logic             in_run;
  logic             go_ok;
  logic             tmo;
  logic             win_rise;
  logic             lose_rise;
  logic             accept;

  assign accept    = (state == IDLE) && start;
  assign in_run    = (state == RUN);
  // first RUN cycle may still show the previous game's GAMEOVER
  assign go_ok     = in_run && (tmr != '0) && gif.GAMEOVER;
  assign tmo       = in_run && (tmr == TW'(TIMEOUT - 1)) && !go_ok;
  assign win_rise  = in_run && gif.WINNER && !win_q;
  assign lose_rise = in_run && gif.LOSER && !lose_q;

  assign mb_src = (state == IDLE) ? mode_base : mb_q;
  assign sd_src = (state == IDLE) ? seed : sd_q;

  always_comb begin
    state_nx = state;
    tmr_nx   = tmr;
    rnd_nx   = rnd;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = LOAD;
          tmr_nx   = '0;
          rnd_nx   = '0;
        end
      end
      LOAD: begin
        if (tmr == TW'(INIT_CYCLES - 1)) begin
          state_nx = RUN;
          tmr_nx   = '0;
        end else begin
          tmr_nx = tmr + TW'(1);
        end
      end
      RUN: begin
        if (go_ok || tmo) begin
          state_nx = NEXT;
          tmr_nx   = '0;
        end else begin
          tmr_nx = tmr + TW'(1);
        end
      end
      NEXT: begin
        if (rnd == 4'(ROUNDS - 1)) begin
          state_nx = DONE;
        end else begin
          state_nx = LOAD;
          rnd_nx   = rnd + 4'd1;
          tmr_nx   = '0;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      tmr    <= '0;
      rnd    <= '0;
      mb_q   <= '0;
      sd_q   <= '0;
      win_q  <= 1'b0;
      lose_q <= 1'b0;
    end else begin
      state  <= state_nx;
      tmr    <= tmr_nx;
      rnd    <= rnd_nx;
      win_q  <= gif.WINNER;
      lose_q <= gif.LOSER;
      if (accept) begin
        mb_q <= mode_base;
        sd_q <= seed;
      end
    end
  end

  // outputs are registered from the next state so they align with it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gif.controlValue <= '0;
      gif.initialValue <= '0;
      gif.INIT         <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      gif.INIT <= (state_nx == LOAD);
      busy     <= (state_nx == LOAD) ||
                  (state_nx == RUN) ||
                  (state_nx == NEXT);
      done     <= (state_nx == DONE);
      if (state_nx == LOAD) begin
        gif.controlValue <= mb_src + rnd_nx[1:0];
        gif.initialValue <= sd_src + INPUT'(rnd_nx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_count     <= '0;
      lose_count    <= '0;
      timeout_count <= '0;
      last_who      <= '0;
    end else if (accept) begin
      win_count     <= '0;
      lose_count    <= '0;
      timeout_count <= '0;
      last_who      <= '0;
    end else begin
      if (win_rise && (win_count != SMAX)) begin
        win_count <= win_count + SCORE_W'(1);
      end
      if (lose_rise && (lose_count != SMAX)) begin
        lose_count <= lose_count + SCORE_W'(1);
      end
      if (tmo && (timeout_count != SMAX)) begin
        timeout_count <= timeout_count + SCORE_W'(1);
      end
      if (go_ok) begin
        last_who <= gif.WHO;
      end
    end
  end

endmodule

// File: doc/game_host.md
# game_host

Sequential host/driver for the GAME counter block: runs a session of ROUNDS games by presenting controlValue and initialValue, pulsing INIT, and monitoring WINNER, LOSER, GAMEOVER and WHO until each game ends or times out. Sits between a session-level controller (start/done) and one GAME instance, taking over the stimulus role that has so far been scripted by hand. Accumulates saturating win, loss and timeout scores for the session.

## Interface
- INPUT, 4, width of initialValue; must match the GAME instance.
- ROUNDS, 4, games per session (1..16).
- INIT_CYCLES, 2, cycles INIT is held high per round (>=1).
- TIMEOUT, 255, max cycles spent in RUN per round (>=2).
- SCORE_W, 8, width of the score counters.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  session request; sampled only in IDLE.
- mode_base  in  2  controlValue for round 0; latched on accepted start.
- seed  in  INPUT  initialValue for round 0; latched on accepted start.
- controlValue  out  2  to GAME.
- initialValue  out  INPUT  to GAME.
- INIT  out  1  to GAME; round load strobe.
- WINNER, LOSER, GAMEOVER  in  1 each  from GAME.
- WHO  in  2  from GAME.
- busy  out  1  session in progress.
- done  out  1  one-cycle pulse at session end.
- win_count, lose_count, timeout_count  out  SCORE_W each  session scores.
- last_who  out  2  WHO captured at the most recent GAMEOVER.

## Operation
- States: IDLE, LOAD, RUN, NEXT, DONE. Round index r, 4 bits.
- IDLE: start=1 -> latch mode_base and seed, clear r, all counters, last_who and timer -> LOAD.
- LOAD: controlValue = mode_base + r (mod 4); initialValue = seed + r (mod 2^INPUT); INIT=1. Stays INIT_CYCLES cycles -> RUN.
- RUN: INIT=0; controlValue/initialValue held stable. Timer counts cycles in RUN from 0.
  - Rising edge of WINNER (registered previous value) -> win_count+1; rising edge of LOSER -> lose_count+1. Both edges in one cycle: both count. Level-high held inputs count once.
  - GAMEOVER is ignored in the first RUN cycle (blanking of stale status); from the second cycle on, GAMEOVER=1 -> last_who <= WHO -> NEXT.
  - Timer reaching TIMEOUT-1 without GAMEOVER -> timeout_count+1 -> NEXT. GAMEOVER and timeout in the same cycle: GAMEOVER wins, no timeout counted.
  - WINNER/LOSER edges coincident with GAMEOVER still count.
- NEXT: r == ROUNDS-1 -> DONE; else r+1 -> LOAD.
- DONE: done=1 for one cycle -> IDLE. Scores and last_who hold until the next accepted start.
- start outside IDLE: ignored. Edge detectors run continuously; edges seen outside RUN are not counted.
- All counters saturate at 2^SCORE_W-1; no wrap.
- rst low at any time: immediate return to IDLE, all outputs to reset values, mid-round state discarded.

## Timing
- All outputs registered. Reset values: controlValue=00, initialValue=0, INIT=0, busy=0, done=0, all counts=0, last_who=00.
- Start accepted at edge k -> LOAD from k+1; INIT high for cycles k+1..k+INIT_CYCLES; busy=1 from k+1.
- RUN begins at cycle k+INIT_CYCLES+1; earliest GAMEOVER acceptance is the following cycle.
- GAMEOVER accepted at cycle m -> NEXT at m+1 -> LOAD (or DONE) at m+2.
- busy=1 in LOAD, RUN, NEXT; busy=0 and done=1 in DONE; neither is high in IDLE.
- Score updates are visible the cycle after the triggering edge/event.

## Test plan
- Reset: assert rst=0 mid-session -> next sampled values INIT=0, busy=0, all counts 0, controlValue=00; start then accepted normally.
- Nominal, ROUNDS=4, mode_base=00, seed=8: behavioral GAME model ends each game -> controlValue sequence 00,01,10,11, initialValue 8,9,10,11, INIT high exactly 2 cycles per round, done pulse once, busy low after it.
- Wrap-around: mode_base=11, seed=15 -> round 1 drives controlValue=00, initialValue=0.
- Timeout: GAMEOVER held low, TIMEOUT=20 -> each round lasts 20 RUN cycles, timeout_count=4 at done; GAMEOVER and timeout coincident -> no timeout counted, last_who captured.
- Scoring: WINNER and LOSER rise together 3 times in one round, WINNER held high 10 cycles -> win_count=3, lose_count=3; SCORE_W=2 with 5 wins -> win_count saturates at 3.
- Blanking/start: GAMEOVER already high on RUN entry -> accepted only on second RUN cycle; start pulsed while busy -> ignored, latched mode_base/seed unchanged.
